// File: rtl/encoder_pkg.sv
// Shared GF(2^4) arithmetic tables, Reed-Solomon generator polynomial and
// encoder FSM state type used by rs_stream_encoder and gf_const_mul.
package encoder_pkg;

    localparam int unsigned GF_W      = 4;
    localparam logic [GF_W:0] PRIM_POLY = 5'b1_0011;   // x^4 + x + 1
    localparam int unsigned GF_ORDER  = (1 << GF_W) - 1;
    localparam int unsigned MAX_PAR   = GF_ORDER - 1;

    typedef logic [GF_W-1:0]     gf_t;
    typedef gf_t [GF_ORDER-1:0]  pow_tab_t;
    typedef gf_t [GF_ORDER:0]    log_tab_t;
    typedef gf_t [MAX_PAR:0]     gen_tab_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MSG  = 2'd1,
        PAR  = 2'd2
    } state_t;

    function automatic pow_tab_t build_pow();
        pow_tab_t t;
        gf_t      v;
        t = '0;
        v = GF_W'(1);
        for (int unsigned i = 0; i < GF_ORDER; i++) begin
            t[GF_W'(i)] = v;
            v = {v[GF_W-2:0], 1'b0} ^ (v[GF_W-1] ? PRIM_POLY[GF_W-1:0] : '0);
        end
        return t;
    endfunction

    localparam pow_tab_t ALPHA_POW = build_pow();

    function automatic log_tab_t build_log();
        log_tab_t t;
        t = '0;
        for (int unsigned i = 0; i < GF_ORDER; i++) begin
            t[ALPHA_POW[GF_W'(i)]] = GF_W'(i);
        end
        return t;
    endfunction

    localparam log_tab_t ALPHA_LOG = build_log();

    function automatic gf_t gf_mul(input gf_t a, input gf_t b);
        int unsigned s;
        if (a == '0 || b == '0) begin
            return '0;
        end
        s = 32'(ALPHA_LOG[a]) + 32'(ALPHA_LOG[b]);
        if (s >= GF_ORDER) begin
            s = s - GF_ORDER;
        end
        return ALPHA_POW[GF_W'(s)];
    endfunction

    // g(x) = prod_{i=1..npar} (x + alpha^i); entry j is the coefficient of x^j
    function automatic gen_tab_t gen_poly(input int unsigned npar);
        gen_tab_t g;
        gf_t      root;
        g    = '0;
        g[0] = GF_W'(1);
        for (int unsigned i = 1; i <= npar; i++) begin
            root = ALPHA_POW[GF_W'(i)];
            for (int unsigned j = MAX_PAR; j > 0; j--) begin
                g[GF_W'(j)] = g[GF_W'(j - 1)] ^ gf_mul(g[GF_W'(j)], root);
            end
            g[0] = gf_mul(g[0], root);
        end
        return g;
    endfunction

endpackage

// File: rtl/gf_const_mul.sv
// GF(2^4) multiply by an elaboration-time constant, flattened to an XOR matrix.
module gf_const_mul
    import encoder_pkg::*;
#(
    parameter gf_t K = '0
) (
    input  logic [GF_W-1:0] a,
    output logic [GF_W-1:0] y
);

    // terms[out_bit][in_bit]: input bit i contributes K*alpha^i
    logic [GF_W-1:0][GF_W-1:0] terms;

    for (genvar i = 0; i < GF_W; i++) begin : g_in
        localparam gf_t COL = gf_mul(K, ALPHA_POW[GF_W'(i)]);
        for (genvar b = 0; b < GF_W; b++) begin : g_out
            assign terms[b][i] = a[i] & COL[b];
        end
    end

    for (genvar b = 0; b < GF_W; b++) begin : g_red
        assign y[b] = ^terms[b];
    end

endmodule

// File: rtl/rs_stream_encoder.sv
// Streaming systematic Reed-Solomon encoder: passes message beats through, then
// emits parity beats. Optional framing checker enabled by ENC_LEN_CHECK_EN.
module rs_stream_encoder
    import encoder_pkg::*;
#(
    parameter int unsigned SYM_W     = GF_W,
    parameter int unsigned BEAT_SYMS = 4,
    parameter int unsigned MSG_BEATS = 2,
    parameter int unsigned PAR_SYMS  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BEAT_SYMS*SYM_W-1:0] in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [BEAT_SYMS*SYM_W-1:0] out_data,
    output logic                       out_valid,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic                       len_err
);

    localparam int unsigned DATA_W    = BEAT_SYMS * SYM_W;
    localparam int unsigned PAR_W     = PAR_SYMS * SYM_W;
    localparam int unsigned PAR_BEATS = PAR_SYMS / BEAT_SYMS;
    localparam int unsigned CNT_W     = $clog2(MSG_BEATS + 1);
    localparam int unsigned PCNT_W    = $clog2(PAR_BEATS + 1);
    localparam gen_tab_t    GEN       = gen_poly(PAR_SYMS);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    msg_cnt, msg_cnt_nxt;
    logic [PCNT_W-1:0]   par_cnt, par_cnt_nxt;
    logic [PAR_W-1:0]    parity, parity_nxt, lfsr_next;
    logic [DATA_W-1:0]   out_data_nxt;
    logic                out_valid_nxt, out_last_nxt;
    logic                out_free, accept, msg_final;

    assign out_free  = !out_valid || out_ready;
    assign in_ready  = !rst && (state != PAR) && out_free;
    assign accept    = in_valid && in_ready;
    assign msg_final = (msg_cnt == CNT_W'(MSG_BEATS - 1));

    // Unrolled LFSR: one division step per symbol, MSB symbol first
    for (genvar k = 0; k < BEAT_SYMS; k++) begin : g_sym
        logic [PAR_W-1:0] cur, prod, nxt;
        logic [SYM_W-1:0] fb;
        if (k == 0) begin : g_first
            assign cur = parity;
        end else begin : g_chain
            assign cur = g_sym[k-1].nxt;
        end
        assign fb = in_data[(BEAT_SYMS-1-k)*SYM_W +: SYM_W] ^ cur[PAR_W-1 -: SYM_W];
        for (genvar j = 0; j < PAR_SYMS; j++) begin : g_tap
            gf_const_mul #(.K(GEN[j])) u_mul (
                .a (fb),
                .y (prod[j*SYM_W +: SYM_W])
            );
        end
        assign nxt = {cur[PAR_W-SYM_W-1:0], SYM_W'(0)} ^ prod;
    end
    assign lfsr_next = g_sym[BEAT_SYMS-1].nxt;

    // Next-state and datapath update
    always_comb begin
        state_nxt     = state;
        msg_cnt_nxt   = msg_cnt;
        par_cnt_nxt   = par_cnt;
        parity_nxt    = parity;
        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;
        out_last_nxt  = out_last;
        if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
        end
        case (state)
            IDLE, MSG: begin
                if (accept) begin
                    parity_nxt    = lfsr_next;
                    out_data_nxt  = in_data;
                    out_valid_nxt = 1'b1;
                    out_last_nxt  = 1'b0;
                    if (msg_final) begin
                        msg_cnt_nxt = '0;
                        state_nxt   = PAR;
                    end else begin
                        msg_cnt_nxt = msg_cnt + CNT_W'(1);
                        state_nxt   = MSG;
                    end
                end
            end
            PAR: begin
                if (out_free) begin
                    out_data_nxt  = parity[PAR_W-1 -: DATA_W];
                    out_valid_nxt = 1'b1;
                    if (par_cnt == PCNT_W'(PAR_BEATS - 1)) begin
                        out_last_nxt = 1'b1;
                        par_cnt_nxt  = '0;
                        parity_nxt   = '0;
                        state_nxt    = IDLE;
                    end else begin
                        out_last_nxt = 1'b0;
                        par_cnt_nxt  = par_cnt + PCNT_W'(1);
                        parity_nxt   = parity << DATA_W;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            msg_cnt   <= '0;
            par_cnt   <= '0;
            parity    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            msg_cnt   <= msg_cnt_nxt;
            par_cnt   <= par_cnt_nxt;
            parity    <= parity_nxt;
            out_data  <= out_data_nxt;
            out_valid <= out_valid_nxt;
            out_last  <= out_last_nxt;
        end
    end

`ifdef ENC_LEN_CHECK_EN
    // Flags in_last disagreeing with the beat count; framing still follows the count
    always_ff @(posedge clk) begin
        if (rst) begin
            len_err <= 1'b0;
        end else begin
            len_err <= accept && (in_last != msg_final);
        end
    end
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign len_err        = 1'b0;
`endif

endmodule

// File: tb/tb_rs_stream_encoder.sv
// Scoreboard bench for rs_stream_encoder at default parameters.
module tb_rs_stream_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic        len_err;

    always #5 clk = ~clk;

    rs_stream_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .len_err   (len_err)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t sb_q[$];
    int   fire_cyc[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   out_cnt = 0;
    int   len_err_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic [3:0] aa;
        r  = '0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ aa;
            aa = aa[3] ? ({aa[2:0], 1'b0} ^ 4'h3) : {aa[2:0], 1'b0};
        end
        return r;
    endfunction

    // Long division of m(x)*x^4 by g(x) = x^4 + 13x^3 + 12x^2 + 8x + 7
    function automatic logic [15:0] model_parity(input logic [15:0] b0, input logic [15:0] b1);
        logic [3:0] c [12];
        logic [3:0] g [5];
        logic [3:0] q;
        g[0] = 4'h7; g[1] = 4'h8; g[2] = 4'hC; g[3] = 4'hD; g[4] = 4'h1;
        for (int i = 0; i < 12; i++) c[i] = '0;
        for (int i = 0; i < 4; i++) begin
            c[4+i] = b1[4*i +: 4];
            c[8+i] = b0[4*i +: 4];
        end
        for (int d = 11; d >= 4; d--) begin
            q = c[d];
            for (int t = 0; t < 5; t++) c[d-4+t] = c[d-4+t] ^ gmul(q, g[t]);
        end
        return {c[3], c[2], c[1], c[0]};
    endfunction

    task automatic drive_beat(input logic [15:0] d, input logic last);
        logic acc;
        acc      = 1'b0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: beat %0h not accepted", d);
        end
    endtask

    task automatic send_cw(input logic [15:0] b0, input logic [15:0] b1,
                           input logic l0, input logic l1, input logic [15:0] par);
        sb_q.push_back({b0, 1'b0});
        sb_q.push_back({b1, 1'b0});
        sb_q.push_back({par, 1'b1});
        drive_beat(b0, l0);
        drive_beat(b1, l1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && sb_q.size() != 0; n++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: pops and compares every transferred output beat
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (len_err) len_err_cnt++;
            if (out_valid && out_ready) begin
                fire_cyc.push_back(cyc);
                out_cnt++;
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h expected none", out_data);
                end else begin
                    e = sb_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_last", 32'(out_last), 32'(e.last));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a0, a1, b0, b1;
        int base, n;
        int exp_len_err;

        @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 0);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_out_last", 32'(out_last), 0);
        check("reset_out_data", 32'(out_data), 0);
        check("reset_len_err", 32'(len_err), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        // Hand vector with the parity beat stalled for 5 cycles
        send_cw(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hDC87);
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_data", 32'(out_data), 32'h0000DC87);
            check("stall_valid", 32'(out_valid), 1);
            check("stall_last", 32'(out_last), 1);
            check("stall_in_ready", 32'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;

        send_cw(16'h0000, 16'h0010, 1'b0, 1'b1, 16'h2B55);
        send_cw(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000);
        drain();

        // Random pairs A, B and A^B
        for (int i = 0; i < 100; i++) begin
            a0 = 16'($urandom); a1 = 16'($urandom);
            b0 = 16'($urandom); b1 = 16'($urandom);
            send_cw(a0, a1, 1'b0, 1'b1, model_parity(a0, a1));
            send_cw(b0, b1, 1'b0, 1'b1, model_parity(b0, b1));
            send_cw(a0 ^ b0, a1 ^ b1, 1'b0, 1'b1, model_parity(a0 ^ b0, a1 ^ b1));
        end
        drain();

        // Back-to-back codewords must stream without bubbles
        base = out_cnt;
        for (int i = 0; i < 8; i++) begin
            a0 = 16'($urandom); a1 = 16'($urandom);
            send_cw(a0, a1, 1'b0, 1'b1, model_parity(a0, a1));
        end
        for (n = 0; n < 100 && out_cnt < base + 24; n++) @(posedge clk);
        if (out_cnt < base + 24) begin
            total++;
            bad++;
            $display("FAIL b2b_timeout: got %0d beats expected 24", out_cnt - base);
        end else begin
            check("b2b_span", 32'(fire_cyc[base+23] - fire_cyc[base]), 23);
        end
        drain();

        // Reset mid-codeword abandons the partial parity
        sb_q.push_back({16'h1234, 1'b0});
        drive_beat(16'h1234, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 1);
        check("post_rst_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        send_cw(16'h0000, 16'h0010, 1'b0, 1'b1, 16'h2B55);

        // Early in_last: codeword still completes by beat count
        send_cw(16'h0000, 16'h0001, 1'b1, 1'b1, 16'hDC87);
        drain();

        check("sb_drain", 32'(sb_q.size()), 0);
`ifdef ENC_LEN_CHECK_EN
        exp_len_err = 1;
`else
        exp_len_err = 0;
`endif
        check("len_err_pulses", 32'(len_err_cnt), 32'(exp_len_err));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
